// File: rtl/pwm_demod_if.sv
// ---------------------------------------------------------------------------
// pwm_demod_if
// Bundle of the signals that run between the PWM demodulator and whoever
// drives and observes it.
//
// Signals:
//   enable        demodulator run request (low = idle)
//   pwm_i         single-bit PWM stream, may be asynchronous to clk
//   sample_o      last completed measurement, SAMPLE_W bits
//   sample_valid  one-cycle pulse when sample_o updates
//   busy          high while a frame is being measured
//
// Modports:
//   master  the controlling side (drives enable and pwm_i)
//   slave   the demodulator itself
// ---------------------------------------------------------------------------
interface pwm_demod_if #(
    parameter int SAMPLE_W = 8
);
    logic                enable;
    logic                pwm_i;
    logic [SAMPLE_W-1:0] sample_o;
    logic                sample_valid;
    logic                busy;

    modport master (
        output enable,
        output pwm_i,
        input  sample_o,
        input  sample_valid,
        input  busy
    );

    modport slave (
        input  enable,
        input  pwm_i,
        output sample_o,
        output sample_valid,
        output busy
    );
endinterface

// File: rtl/pwm_demod.sv
// ---------------------------------------------------------------------------
// pwm_demod
// Receive-side PWM demodulator. pwm_i is synchronized, then the number of
// high cycles over a frame of 2^SAMPLE_W cycles is counted and latched into
// sample_o, with a one-cycle sample_valid pulse at each frame end. Frames
// follow each other back to back. A full-scale count of 2^SAMPLE_W is
// saturated to 2^SAMPLE_W-1.
//
// Parameters:
//   SAMPLE_W     width of the reconstructed sample (frame = 2^SAMPLE_W cycles)
//   SYNC_STAGES  depth of the input synchronizer (>= 2)
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   pwm_demod_if slave modport (enable, pwm_i, sample_o,
//         sample_valid, busy)
//
// Optional feature:
//   PWM_DEMOD_EDGE_ALIGN_EN  when defined, an ALIGN state waits for a rising
//                            edge of the synchronized stream so frames start
//                            on the PWM period boundary; it gives up after
//                            2^SAMPLE_W cycles and measures unaligned.
// ---------------------------------------------------------------------------
module pwm_demod #(
    parameter int SAMPLE_W    = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    pwm_demod_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILL    = 2'd1;
`ifdef PWM_DEMOD_EDGE_ALIGN_EN
    localparam logic [1:0] ST_ALIGN   = 2'd2;
`endif
    localparam logic [1:0] ST_MEASURE = 2'd3;

    localparam int                  FILL_W     = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;
    localparam logic [FILL_W-1:0]   FILL_LAST  = FILL_W'(SYNC_STAGES - 1);
    localparam logic [SAMPLE_W-1:0] FRAME_LAST = {SAMPLE_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;

    logic [1:0]          state;
    logic [FILL_W-1:0]   fill_cnt;
    logic [SAMPLE_W-1:0] fcnt;
    logic [SAMPLE_W:0]   hcnt;
    logic [SAMPLE_W-1:0] sample_q;
    logic                valid_q;

    logic [SAMPLE_W:0]   hcnt_next;
    logic [SAMPLE_W-1:0] hcnt_sat;

    // Input synchronizer; only its last stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_i};
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEMOD_EDGE_ALIGN_EN
    logic pwm_prev;

    // Previous synchronized level, for rising-edge detection in ALIGN.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_prev <= 1'b0;
        end else begin
            pwm_prev <= pwm_s;
        end
    end
`endif

    // High count including the current cycle; the final frame cycle can
    // reach 2^SAMPLE_W, which does not fit the output and is clamped.
    always_comb begin
        hcnt_next = hcnt + {{SAMPLE_W{1'b0}}, pwm_s};
        hcnt_sat  = hcnt_next[SAMPLE_W] ? {SAMPLE_W{1'b1}} : hcnt_next[SAMPLE_W-1:0];
    end

    // Control FSM and counters. Dropping enable in any state returns to
    // IDLE and throws away the partial frame, even on its last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fill_cnt <= '0;
            fcnt     <= '0;
            hcnt     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.enable) begin
                state    <= ST_IDLE;
                fill_cnt <= '0;
                fcnt     <= '0;
                hcnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                        fcnt     <= '0;
                        hcnt     <= '0;
                    end
                    ST_FILL: begin
                        if (fill_cnt == FILL_LAST) begin
`ifdef PWM_DEMOD_EDGE_ALIGN_EN
                            state <= ST_ALIGN;
`else
                            state <= ST_MEASURE;
`endif
                            fill_cnt <= '0;
                            fcnt     <= '0;
                            hcnt     <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
`ifdef PWM_DEMOD_EDGE_ALIGN_EN
                    // fcnt doubles as the timeout counter here. The edge
                    // cycle itself is the first cycle of the frame.
                    ST_ALIGN: begin
                        if (pwm_s && !pwm_prev) begin
                            state <= ST_MEASURE;
                            fcnt  <= SAMPLE_W'(1);
                            hcnt  <= (SAMPLE_W+1)'(1);
                        end else if (fcnt == FRAME_LAST) begin
                            state <= ST_MEASURE;
                            fcnt  <= '0;
                            hcnt  <= '0;
                        end else begin
                            fcnt <= fcnt + SAMPLE_W'(1);
                        end
                    end
`endif
                    ST_MEASURE: begin
                        if (fcnt == FRAME_LAST) begin
                            sample_q <= hcnt_sat;
                            valid_q  <= 1'b1;
                            fcnt     <= '0;
                            hcnt     <= '0;
                        end else begin
                            fcnt <= fcnt + SAMPLE_W'(1);
                            hcnt <= hcnt_next;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sample_o     = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_pwm_demod.sv
// ---------------------------------------------------------------------------
// tb_pwm_demod
// Directed testbench for pwm_demod in its default build
// (PWM_DEMOD_EDGE_ALIGN_EN undefined), SAMPLE_W=8, SYNC_STAGES=2.
// A small PWM source (period 256, high while its phase counter < duty)
// drives pwm_i on the falling clock edge; expected samples and pulse
// timings are fixed, hand-derived values.
// ---------------------------------------------------------------------------
module tb_pwm_demod;

    logic clk;
    logic rst;

    pwm_demod_if #(.SAMPLE_W(8)) bus ();

    pwm_demod #(
        .SAMPLE_W   (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Source mode: 0 = constant 0, 1 = constant 1, 2 = PWM at duty, 3 = toggle
    int         src_mode = 3;
    int         duty     = 0;
    logic [7:0] phase    = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PWM source, updated away from the sampling edge.
    initial begin
        bus.pwm_i = 1'b0;
        forever begin
            @(negedge clk);
            case (src_mode)
                0: bus.pwm_i = 1'b0;
                1: bus.pwm_i = 1'b1;
                2: bus.pwm_i = (int'(phase) < duty);
                default: bus.pwm_i = ~bus.pwm_i;
            endcase
            phase = phase + 8'd1;
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v);
        rst        = rst_v;
        bus.enable = en_v;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until sample_valid is seen; n is the number of ticks taken.
    task automatic waitValid(input string tag, input int max_ticks, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.sample_valid && n < max_ticks);
        if (!bus.sample_valid) begin
            checkOutput({tag, "_timeout"}, 0, 1);
        end
    endtask

    int n;
    int trans;
    int bad_valid;
    int bad_hold;

    initial begin
        applyStimulus(1'b1, 1'b0);

        // Reset with pwm_i toggling.
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_sample", int'(bus.sample_o), 0);
            checkOutput("rst_valid", int'(bus.sample_valid), 0);
            checkOutput("rst_busy", int'(bus.busy), 0);
        end
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("rel_sample", int'(bus.sample_o), 0);
        checkOutput("rel_valid", int'(bus.sample_valid), 0);
        checkOutput("rel_busy", int'(bus.busy), 0);

        // Half duty: first pulse 258 edges after the enable edge.
        src_mode = 2;
        duty     = 127;
        tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("half_busy", int'(bus.busy), 1);
        waitValid("half_first", 400, n);
        checkOutput("half_first_lat", n + 1, 259);
        checkOutput("half_first_val", int'(bus.sample_o), 127);
        tick();
        checkOutput("half_pulse_1cyc", int'(bus.sample_valid), 0);
        waitValid("half_second", 400, n);
        checkOutput("half_second_lat", n + 1, 256);
        checkOutput("half_second_val", int'(bus.sample_o), 127);

        // Constant low.
        applyStimulus(1'b0, 1'b0);
        src_mode = 0;
        tick();
        tick();
        checkOutput("idle_busy", int'(bus.busy), 0);
        checkOutput("idle_hold", int'(bus.sample_o), 127);
        applyStimulus(1'b0, 1'b1);
        waitValid("zero", 400, n);
        checkOutput("zero_lat", n, 259);
        checkOutput("zero_val", int'(bus.sample_o), 0);

        // Constant high saturates.
        applyStimulus(1'b0, 1'b0);
        src_mode = 1;
        tick();
        tick();
        applyStimulus(1'b0, 1'b1);
        waitValid("full", 400, n);
        checkOutput("full_lat", n, 259);
        checkOutput("full_val", int'(bus.sample_o), 255);

        // Abort 100 cycles into MEASURE.
        applyStimulus(1'b0, 1'b0);
        src_mode = 2;
        duty     = 127;
        tick();
        tick();
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 103; i++) tick();
        checkOutput("abort_busy_before", int'(bus.busy), 1);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("abort_busy_after", int'(bus.busy), 0);
        bad_valid = 0;
        bad_hold  = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.sample_valid) bad_valid++;
            if (bus.sample_o != 8'd255) bad_hold++;
        end
        checkOutput("abort_no_valid", bad_valid, 0);
        checkOutput("abort_hold", bad_hold, 0);
        applyStimulus(1'b0, 1'b1);
        waitValid("reenable", 400, n);
        checkOutput("reenable_lat", n, 259);
        checkOutput("reenable_val", int'(bus.sample_o), 127);

        // Disable on the final cycle of a frame: no pulse.
        for (int i = 0; i < 255; i++) tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("lastcyc_no_valid", int'(bus.sample_valid), 0);
        checkOutput("lastcyc_hold", int'(bus.sample_o), 127);
        applyStimulus(1'b0, 1'b1);
        waitValid("lastcyc_re", 400, n);

        // Reset 150 cycles into a frame, enable kept high.
        for (int i = 0; i < 150; i++) tick();
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("midrst_sample", int'(bus.sample_o), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_valid", int'(bus.sample_valid), 0);
        applyStimulus(1'b0, 1'b1);
        waitValid("midrst_re", 400, n);
        checkOutput("midrst_lat", n, 259);
        checkOutput("midrst_val", int'(bus.sample_o), 127);

        // Value change 64 -> 200 mid-stream.
        applyStimulus(1'b0, 1'b0);
        duty = 64;
        tick();
        tick();
        applyStimulus(1'b0, 1'b1);
        waitValid("chg_a", 400, n);
        checkOutput("chg_64", int'(bus.sample_o), 64);
        for (int i = 0; i < 100; i++) tick();
        duty = 200;
        waitValid("chg_t", 400, n);
        trans = int'(bus.sample_o);
        checkOutput("chg_trans_range", int'(trans >= 64 && trans <= 200), 1);
        waitValid("chg_b", 400, n);
        checkOutput("chg_200_a", int'(bus.sample_o), 200);
        waitValid("chg_c", 400, n);
        checkOutput("chg_200_b", int'(bus.sample_o), 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_demod.md
# pwm_demod

Receive-side counterpart of the synthesizer's PWM output stage. It samples a single-bit PWM stream, measures how many cycles it is high over a fixed frame of 2^SAMPLE_W cycles, and reconstructs the SAMPLE_W-bit sample value. It sits in the loopback and self-check path behind `pwm`, so mixed samples can be recovered on chip and compared against what was sent.

## Interface
- SAMPLE_W, 8: width of the reconstructed sample; frame length = 2^SAMPLE_W cycles
- SYNC_STAGES, 2: flip-flops in the input synchronizer (≥2)
- clk  input  1  system clock (10 MHz nominal)
- rst  input  1  reset; one clock, synchronous, active-high
- enable  input  1  demodulator run; low = idle
- pwm_i  input  1  PWM stream (may be asynchronous to clk)
- sample_o  output  SAMPLE_W  last completed measurement; held between frames
- sample_valid  output  1  one-cycle pulse when sample_o updates
- busy  output  1  high while a frame is being measured

## Operation
- pwm_i passes through a SYNC_STAGES-deep flop chain; all logic uses the last stage (`pwm_s`). The chain clears to 0 on rst.
- FSM states:
  - IDLE: counters cleared. Go to FILL when enable=1.
  - FILL: discard SYNC_STAGES cycles so stale synchronizer contents are flushed. Then go to MEASURE, or ALIGN if the macro is defined.
  - ALIGN (macro only): described under Configuration.
  - MEASURE: see below.
- MEASURE:
  - frame counter `fcnt` (SAMPLE_W bits) counts 0..2^SAMPLE_W−1.
  - high counter `hcnt` (SAMPLE_W+1 bits) increments on every cycle where pwm_s=1.
  - On the cycle with fcnt=2^SAMPLE_W−1, the final hcnt value (including that cycle) is latched into sample_o and sample_valid pulses.
  - The latched value saturates: 2^SAMPLE_W maps to 2^SAMPLE_W−1.
  - fcnt wraps to 0, hcnt reloads to 0, and the next frame starts with no gap cycle.
- Window phase does not affect the result for periodic input: any 2^SAMPLE_W-cycle window of a constant-duty stream yields the same high count.
- enable=0 in any state:
  - next state is IDLE; the partial frame is discarded.
  - no sample_valid is produced.
  - sample_o keeps its last value.
- busy = 1 in FILL, ALIGN and MEASURE.

## Timing
- Reset values: sample_o=0, sample_valid=0, busy=0, state=IDLE, all counters 0.
- rst overrides enable; rst mid-frame aborts it and clears sample_o.
- enable sampled high at edge E0: FILL occupies edges E1..E2 (with SYNC_STAGES=2), then MEASURE starts.
- First sample_valid at edge E0+SYNC_STAGES+2^SAMPLE_W (edge 258 for the defaults). Subsequent pulses come every 256 edges.
- pwm_i-to-count latency: SYNC_STAGES cycles.
- enable deasserted on the same edge as a frame's final cycle: the frame is discarded and no valid pulse is issued.
- sample_valid is never high for two consecutive cycles.

## Configuration
- PWM_DEMOD_EDGE_ALIGN_EN
  - Defined: after FILL the FSM enters ALIGN and waits for a rising edge of pwm_s (0 then 1). MEASURE starts with fcnt=0 on that edge's cycle, so frames align to the `pwm` period start.
  - If no rising edge arrives within 2^SAMPLE_W cycles (constant input), ALIGN times out to MEASURE unaligned.
  - Undefined: no ALIGN state; FILL goes straight to MEASURE.

## Test plan
- Reset: rst=1 for 2 cycles with pwm_i toggling → sample_o=0, sample_valid=0, busy=0 throughout; still 0 one cycle after release.
- Half duty: `pwm` model with sample 127, enable at E0 → first sample_valid at E0+258, sample_o=127; next pulse 256 cycles later, sample_o=127.
- Extremes: pwm_i=0 constant → sample_o=0. pwm_i=1 constant → sample_o=255 (saturated from 256). With the macro defined, both cases reach MEASURE via the ALIGN timeout, delaying valid by 256 cycles.
- Value change: sample switches from 64 to 200 mid-stream → one transitional value between 64 and 200, then sample_o=200 on every later frame (within one frame for the aligned build).
- Abort: enable dropped 100 cycles into MEASURE → busy falls next cycle, no valid, sample_o unchanged. Re-enable → first valid after a full 258 cycles.
- Reset mid-frame: rst at cycle 150 of a frame → sample_o=0, state IDLE; measurement restarts cleanly once enable is seen after release.
